// File: rtl/mul_sigcalc_iter_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mul_sigcalc_iter_if                                                        |
// | Operand/result handshake bundle for the iterative significand multiplier.  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
interface mul_sigcalc_iter_if #(
    parameter int sig_width = 23
);
    logic                 in_valid;
    logic                 in_ready;
    logic [sig_width:0]   x;
    logic [sig_width:0]   y;
    logic                 out_valid;
    logic                 out_ready;
    logic [sig_width:0]   product;
    logic                 guard_bit;
    logic                 round_bit;
    logic                 sticky_bit;
    logic                 count;

    modport master (
        output in_valid, x, y, out_ready,
        input  in_ready, out_valid, product, guard_bit, round_bit, sticky_bit, count
    );

    modport slave (
        input  in_valid, x, y, out_ready,
        output in_ready, out_valid, product, guard_bit, round_bit, sticky_bit, count
    );
endinterface
`default_nettype wire

// File: rtl/mul_sigcalc_iter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mul_sigcalc_iter                                                           |
// | Iterative radix-4 Booth significand multiplier with normalized G/R/S out.  |
// | Optional macro MUL_SIGCALC_OUTREG_EN adds one output register stage.       |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module mul_sigcalc_iter #(
    parameter int sig_width = 23
) (
    input  wire logic            clk,
    input  wire logic            resetn,
    input  wire logic            enable,
    mul_sigcalc_iter_if.slave    bus
);
    localparam int c_N     = sig_width + 1;
    localparam int c_STEPS = (sig_width + 1) / 2 + 1;
    localparam int c_AW    = 2 * c_N + 2;
    localparam int c_IW    = $clog2(c_STEPS);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic [c_AW-1:0]   r_acc;
    logic [c_AW-1:0]   r_xs;
    logic [c_N-1:0]    r_y;
    logic [c_IW-1:0]   r_i;
    logic [c_N-1:0]    r_prod;
    logic              r_guard;
    logic              r_round;
    logic              r_sticky;
    logic              r_count;

    logic              w_in_ready;
    logic              w_accept;
    logic              w_last;
    logic              w_retire;
    logic              w_out_valid;
    logic [c_N+2:0]    w_yext;
    logic [c_IW:0]     w_idx;
    logic [2:0]        w_win;
    logic [c_AW-1:0]   w_pp;
    logic [c_AW-1:0]   w_acc_next;
    logic [2*c_N-1:0]  w_p;
    logic [c_N-1:0]    w_prod;
    logic              w_guard;
    logic              w_round;
    logic              w_sticky;
    logic              w_count;

    assign w_in_ready = enable & resetn & (r_state == S_IDLE);
    assign w_accept   = w_in_ready & bus.in_valid;
    assign w_last     = (r_state == S_RUN) && (r_i == c_IW'(c_STEPS - 1));

    // Booth window {y[2i+1], y[2i], y[2i-1]} with y[-1] and y[>=N] reading 0
    assign w_yext = {2'b00, r_y, 1'b0};
    assign w_idx  = {r_i, 1'b0};
    assign w_win  = w_yext[w_idx +: 3];

    // r_xs already carries the 2i weight, so each digit adds at a fixed position
    always_comb begin
        w_pp = '0;
        case (w_win)
            3'b001, 3'b010: w_pp = r_xs;
            3'b011:         w_pp = r_xs << 1;
            3'b100:         w_pp = -(r_xs << 1);
            3'b101, 3'b110: w_pp = -r_xs;
            default:        w_pp = '0;
        endcase
    end

    assign w_acc_next = r_acc + w_pp;
    assign w_p        = w_acc_next[2*c_N-1:0];

    always_comb begin
        w_count  = w_p[2*c_N-1];
        w_prod   = w_p[2*c_N-2 -: c_N];
        w_guard  = w_p[c_N-2];
        w_round  = w_p[c_N-3];
        w_sticky = |w_p[c_N-4:0];
        if (w_count) begin
            w_prod   = w_p[2*c_N-1 -: c_N];
            w_guard  = w_p[c_N-1];
            w_round  = w_p[c_N-2];
            w_sticky = |w_p[c_N-3:0];
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept)          w_state_next = S_RUN;
            S_RUN:   if (enable && w_last)  w_state_next = S_DONE;
            S_DONE:  if (w_retire)          w_state_next = S_IDLE;
            default:                        w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_acc    <= '0;
            r_xs     <= '0;
            r_y      <= '0;
            r_i      <= '0;
            r_prod   <= '0;
            r_guard  <= 1'b0;
            r_round  <= 1'b0;
            r_sticky <= 1'b0;
            r_count  <= 1'b0;
        end else if (enable) begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_xs  <= {{(c_AW-c_N){1'b0}}, bus.x};
                        r_y   <= bus.y;
                        r_acc <= '0;
                        r_i   <= '0;
                    end
                end
                S_RUN: begin
                    r_acc <= w_acc_next;
                    r_xs  <= r_xs << 2;
                    r_i   <= r_i + c_IW'(1);
                    if (w_last) begin
                        r_prod   <= w_prod;
                        r_guard  <= w_guard;
                        r_round  <= w_round;
                        r_sticky <= w_sticky;
                        r_count  <= w_count;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef MUL_SIGCALC_OUTREG_EN
    logic           r_ov;
    logic [c_N-1:0] r_oprod;
    logic           r_oguard;
    logic           r_oround;
    logic           r_osticky;
    logic           r_ocount;

    // Load once on entering DONE; the FSM waits in DONE until this stage is retired
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_ov      <= 1'b0;
            r_oprod   <= '0;
            r_oguard  <= 1'b0;
            r_oround  <= 1'b0;
            r_osticky <= 1'b0;
            r_ocount  <= 1'b0;
        end else if (enable) begin
            if ((r_state == S_DONE) && !r_ov) begin
                r_ov      <= 1'b1;
                r_oprod   <= r_prod;
                r_oguard  <= r_guard;
                r_oround  <= r_round;
                r_osticky <= r_sticky;
                r_ocount  <= r_count;
            end else if (w_retire) begin
                r_ov <= 1'b0;
            end
        end
    end

    assign w_out_valid    = r_ov;
    assign bus.product    = r_oprod;
    assign bus.guard_bit  = r_oguard;
    assign bus.round_bit  = r_oround;
    assign bus.sticky_bit = r_osticky;
    assign bus.count      = r_ocount;
`else
    assign w_out_valid    = (r_state == S_DONE);
    assign bus.product    = r_prod;
    assign bus.guard_bit  = r_guard;
    assign bus.round_bit  = r_round;
    assign bus.sticky_bit = r_sticky;
    assign bus.count      = r_count;
`endif

    assign w_retire      = w_out_valid & bus.out_ready & enable;
    assign bus.out_valid = w_out_valid;
    assign bus.in_ready  = w_in_ready;

    // The exact product of two N-bit operands never reaches bit 2N
    a_acc_in_range: assert property (@(posedge clk) disable iff (!resetn)
        (r_state == S_DONE) |-> (r_acc[c_AW-1:2*c_N] == '0));

endmodule
`default_nettype wire

// File: tb/tb_mul_sigcalc_iter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_mul_sigcalc_iter                                                        |
// | Random and directed stimulus against an arithmetic product model.          |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_mul_sigcalc_iter;
    localparam int c_N     = 24;
    localparam int c_STEPS = c_N / 2 + 1;
`ifdef MUL_SIGCALC_OUTREG_EN
    localparam int c_LAT = c_STEPS + 2;
`else
    localparam int c_LAT = c_STEPS + 1;
`endif
    localparam int c_RW = c_N + 4;

    logic clk = 1'b0;
    logic resetn;
    logic enable;
    int   n_tests = 0;
    int   n_fail  = 0;
    logic [c_RW-1:0] exp_q[$];
    logic [c_RW-1:0] dut_res;

    mul_sigcalc_iter_if #(.sig_width(c_N - 1)) bif();

    mul_sigcalc_iter #(.sig_width(c_N - 1)) dut (
        .clk    (clk),
        .resetn (resetn),
        .enable (enable),
        .bus    (bif)
    );

    always #5 clk = ~clk;

    assign dut_res = {bif.product, bif.guard_bit, bif.round_bit, bif.sticky_bit, bif.count};

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Packed as {product, guard, round, sticky, count}
    function automatic logic [c_RW-1:0] model(input logic [c_N-1:0] a, input logic [c_N-1:0] b);
        longint unsigned pa, pb, p;
        logic [c_N-1:0] prod;
        logic g, r, s, c;
        pa = 64'(a);
        pb = 64'(b);
        p  = pa * pb;
        c  = (p >= (64'd1 << (2*c_N - 1)));
        if (c) begin
            prod = c_N'(p >> c_N);
            g    = ((p >> (c_N - 1)) & 64'd1) != 0;
            r    = ((p >> (c_N - 2)) & 64'd1) != 0;
            s    = (p % (64'd1 << (c_N - 2))) != 0;
        end else begin
            prod = c_N'(p >> (c_N - 1));
            g    = ((p >> (c_N - 2)) & 64'd1) != 0;
            r    = ((p >> (c_N - 3)) & 64'd1) != 0;
            s    = (p % (64'd1 << (c_N - 3))) != 0;
        end
        return {prod, g, r, s, c};
    endfunction

    always @(negedge clk) begin
        if (resetn === 1'b1) begin
            if (bif.out_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_out_valid", 64'(bif.out_valid), 64'd0);
                end else begin
                    chk("result_vs_model", 64'(dut_res), 64'(exp_q[0]));
                    chk("in_ready_while_valid", 64'(bif.in_ready), 64'd0);
                    if (bif.out_ready && enable) void'(exp_q.pop_front());
                end
            end
            if (bif.in_valid && bif.in_ready) exp_q.push_back(model(bif.x, bif.y));
        end
    end

    // Accept edge counts as cycle 1; lat is the cycle in which out_valid is first seen
    task automatic do_op(input logic [c_N-1:0] a, input logic [c_N-1:0] b, input int stall,
                         input int gap_at, input int gap_len,
                         output logic [c_RW-1:0] res, output int lat);
        int k;
        res = '0;
        lat = 0;
        @(posedge clk); #1;
        bif.in_valid  = 1'b1;
        bif.x         = a;
        bif.y         = b;
        bif.out_ready = 1'b0;
        k = 0;
        while (k < 50) begin
            @(negedge clk);
            if (bif.in_ready) break;
            k++;
        end
        if (k >= 50) chk("accept_timeout", 64'(k), 64'd0);
        @(posedge clk); #1;
        bif.in_valid = 1'b0;
        bif.x        = c_N'($urandom);
        bif.y        = c_N'($urandom);
        lat = 1;
        while (lat < 200) begin
            @(negedge clk);
            if (bif.out_valid) break;
            @(posedge clk);
            lat++;
            if (gap_len > 0 && lat == gap_at) begin #1; enable = 1'b0; end
            if (gap_len > 0 && lat == gap_at + gap_len) begin #1; enable = 1'b1; end
        end
        if (lat >= 200) chk("result_timeout", 64'(lat), 64'd0);
        res = dut_res;
        repeat (stall) begin
            @(posedge clk); #1;
            chk("stall_in_ready", 64'(bif.in_ready), 64'd0);
            chk("stall_out_valid", 64'(bif.out_valid), 64'd1);
        end
        @(posedge clk); #1;
        bif.out_ready = 1'b1;
        @(posedge clk); #1;
        bif.out_ready = 1'b0;
        chk("retired_out_valid", 64'(bif.out_valid), 64'd0);
        chk("idle_in_ready", 64'(bif.in_ready), 64'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [c_RW-1:0] res;
        int lat;
        int k;
        logic [c_N-1:0] a, b;
        int st, ga, gl;

        resetn        = 1'b0;
        enable        = 1'b1;
        bif.in_valid  = 1'b0;
        bif.x         = '0;
        bif.y         = '0;
        bif.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_in_ready", 64'(bif.in_ready), 64'd0);
        chk("reset_out_valid", 64'(bif.out_valid), 64'd0);
        chk("reset_outputs", 64'(dut_res), 64'd0);
        resetn = 1'b1;
        #1;
        chk("idle_after_reset", 64'(bif.in_ready), 64'd1);

        chk("model_1x1", 64'(model(24'h800000, 24'h800000)), 64'({24'h800000, 4'b0000}));
        chk("model_1p5sq", 64'(model(24'hC00000, 24'hC00000)), 64'({24'h900000, 4'b0001}));
        chk("model_max", 64'(model(24'hFFFFFF, 24'hFFFFFF)), 64'({24'hFFFFFE, 4'b0011}));

        do_op(24'h800000, 24'h800000, 0, 0, 0, res, lat);
        chk("case1_result", 64'(res), 64'({24'h800000, 4'b0000}));
        chk("case1_latency", 64'(lat), 64'(c_LAT));

        do_op(24'hC00000, 24'hC00000, 0, 0, 0, res, lat);
        chk("case2_result", 64'(res), 64'({24'h900000, 4'b0001}));

        do_op(24'hFFFFFF, 24'hFFFFFF, 0, 0, 0, res, lat);
        chk("case3_result", 64'(res), 64'({24'hFFFFFE, 4'b0011}));

        do_op(24'hABCDEF, 24'h812345, 5, 0, 0, res, lat);
        chk("case4_latency", 64'(lat), 64'(c_LAT));

        do_op(24'hC00000, 24'hC00000, 0, 5, 3, res, lat);
        chk("case5_result", 64'(res), 64'({24'h900000, 4'b0001}));
        chk("case5_latency", 64'(lat), 64'(c_LAT + 3));

        // Abort an operation with the counter at 6
        @(posedge clk); #1;
        bif.in_valid = 1'b1;
        bif.x        = 24'hC00000;
        bif.y        = 24'hC00000;
        k = 0;
        while (k < 50) begin
            @(negedge clk);
            if (bif.in_ready) break;
            k++;
        end
        @(posedge clk); #1;
        bif.in_valid = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        resetn = 1'b0;
        #1;
        chk("abort_out_valid", 64'(bif.out_valid), 64'd0);
        chk("abort_in_ready", 64'(bif.in_ready), 64'd0);
        chk("abort_outputs", 64'(dut_res), 64'd0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        resetn = 1'b1;
        do_op(24'h800000, 24'h800000, 0, 0, 0, res, lat);
        chk("case6_result", 64'(res), 64'({24'h800000, 4'b0000}));
        chk("case6_latency", 64'(lat), 64'(c_LAT));

        for (int n = 0; n < 40; n++) begin
            a = c_N'($urandom);
            b = c_N'($urandom);
            if ($urandom_range(0, 3) != 0) a[c_N-1] = 1'b1;
            if ($urandom_range(0, 3) != 0) b[c_N-1] = 1'b1;
            st = $urandom_range(0, 3);
            ga = $urandom_range(2, 10);
            gl = $urandom_range(0, 3);
            do_op(a, b, st, ga, gl, res, lat);
            chk("rand_latency", 64'(lat), 64'(c_LAT + gl));
        end

        repeat (3) @(posedge clk);
        chk("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
